// File: rtl/reg_status_file_pkg.sv
// reg_status_file_pkg: shared widths, tag encoding and storage types for the register status file.
package reg_status_file_pkg;
    localparam int TAG_W = 4;
    localparam int XLEN = 32;
    localparam int REG_CNT = 32;
    localparam int REG_IDX_W = 5;
    localparam logic [TAG_W-1:0] NO_TAG = '0;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [XLEN-1:0] word_t;
    typedef logic [REG_IDX_W-1:0] idx_t;
endpackage

// File: rtl/reg_status_file_read_port.sv
// reg_status_file_read_port: one combinational source-operand read with same-cycle commit bypass.
module reg_status_file_read_port
    import reg_status_file_pkg::*;
(
    input  idx_t  idx_i,
    input  word_t stored_val_i,
    input  tag_t  stored_tag_i,
    input  logic  cdb_active_i,
    input  tag_t  cdb_tag_i,
    input  word_t cdb_val_i,
    output word_t val_o,
    output tag_t  tag_o
);
    logic hit;
    assign hit   = stored_tag_i != NO_TAG && cdb_active_i && cdb_tag_i == stored_tag_i;
    assign val_o = idx_i == '0 ? '0 : hit ? cdb_val_i : stored_val_i;
    assign tag_o = (idx_i == '0 || hit) ? NO_TAG : stored_tag_i;
endmodule

// File: rtl/reg_status_file.sv
// reg_status_file: architectural registers plus rename tags, updated by commit, dispatch and flush.
module reg_status_file
    import reg_status_file_pkg::*;
(
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rdy_in,
    input  logic  issue_valid,
    input  idx_t  issue_rd_idx,
    input  tag_t  issue_rob_tag,
    input  logic  cdb_active,
    input  tag_t  cdb_tag,
    input  word_t cdb_val,
    input  idx_t  cdb_rd_idx,
    input  logic  predict_fail,
    input  idx_t  rs1_idx,
    input  idx_t  rs2_idx,
    output word_t rs1_val,
    output tag_t  rs1_tag,
    output word_t rs2_val,
    output tag_t  rs2_tag,
    output logic [31:0] commit_cnt
);
    word_t       val_q [REG_CNT];
    word_t       val_d [REG_CNT];
    tag_t        tag_q [REG_CNT];
    tag_t        tag_d [REG_CNT];
    logic [31:0] cnt_q, cnt_d;

    // Commit first, then issue/flush, so a same-cycle issue overrides the tag clear.
    always_comb begin
        val_d = val_q;
        tag_d = tag_q;
        cnt_d = cnt_q;
        if (rdy_in) begin
            if (cdb_active) begin
                if (cdb_rd_idx != '0) begin
                    val_d[cdb_rd_idx] = cdb_val;
                    if (tag_q[cdb_rd_idx] == cdb_tag) tag_d[cdb_rd_idx] = NO_TAG;
                end
                cnt_d = cnt_q + 32'd1;
            end
            if (predict_fail) tag_d = '{default: NO_TAG};
            else if (issue_valid && issue_rd_idx != '0) tag_d[issue_rd_idx] = issue_rob_tag;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            val_q <= '{default: '0};
            tag_q <= '{default: NO_TAG};
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            tag_q <= tag_d;
            cnt_q <= cnt_d;
        end
    end

    assign commit_cnt = cnt_q;

    reg_status_file_read_port u_rd1 (
        .idx_i(rs1_idx), .stored_val_i(val_q[rs1_idx]), .stored_tag_i(tag_q[rs1_idx]),
        .cdb_active_i(cdb_active), .cdb_tag_i(cdb_tag), .cdb_val_i(cdb_val),
        .val_o(rs1_val), .tag_o(rs1_tag)
    );

    reg_status_file_read_port u_rd2 (
        .idx_i(rs2_idx), .stored_val_i(val_q[rs2_idx]), .stored_tag_i(tag_q[rs2_idx]),
        .cdb_active_i(cdb_active), .cdb_tag_i(cdb_tag), .cdb_val_i(cdb_val),
        .val_o(rs2_val), .tag_o(rs2_tag)
    );
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: directed and random stimulus against an array-based reference, checked through a scoreboard queue.
module tb_reg_status_file;
    import reg_status_file_pkg::*;

    logic clk_in = 0, rst_in = 0, rdy_in = 0;
    logic issue_valid = 0, cdb_active = 0, predict_fail = 0;
    logic [4:0] issue_rd_idx = 0, cdb_rd_idx = 0, rs1_idx = 0, rs2_idx = 0;
    logic [TAG_W-1:0] issue_rob_tag = 0, cdb_tag = 0, rs1_tag, rs2_tag;
    logic [XLEN-1:0] cdb_val = 0, rs1_val, rs2_val;
    logic [31:0] commit_cnt;

    typedef struct {
        logic [XLEN-1:0] v1, v2;
        logic [TAG_W-1:0] t1, t2;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t me;
    logic [XLEN-1:0] mval [32];
    logic [TAG_W-1:0] mtag [32];
    logic [31:0] mcnt = 0;
    int vecs = 0, errs = 0;

    reg_status_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd_idx(issue_rd_idx), .issue_rob_tag(issue_rob_tag),
        .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_rd_idx(cdb_rd_idx),
        .predict_fail(predict_fail), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_val(rs1_val), .rs1_tag(rs1_tag), .rs2_val(rs2_val), .rs2_tag(rs2_tag),
        .commit_cnt(commit_cnt)
    );

    always #5 clk_in = ~clk_in;

    function automatic void ref_read(input logic [4:0] idx, output logic [XLEN-1:0] v, output logic [TAG_W-1:0] t);
        if (idx == 0) begin
            v = 0; t = 0;
        end else if (mtag[idx] != 0 && cdb_active && cdb_tag == mtag[idx]) begin
            v = cdb_val; t = 0;
        end else begin
            v = mval[idx]; t = mtag[idx];
        end
    endfunction

    task automatic push_expect();
        exp_t e;
        ref_read(rs1_idx, e.v1, e.t1);
        ref_read(rs2_idx, e.v2, e.t2);
        e.cnt = mcnt;
        q.push_back(e);
    endtask

    task automatic step(input logic iv, input logic [4:0] ird, input logic [TAG_W-1:0] itag,
                        input logic ca, input logic [TAG_W-1:0] ctag, input logic [XLEN-1:0] cval,
                        input logic [4:0] crd, input logic pf, input logic [4:0] r1, input logic [4:0] r2,
                        input logic rdy);
        @(posedge clk_in); #1;
        rst_in = 1; rdy_in = rdy;
        issue_valid = iv; issue_rd_idx = ird; issue_rob_tag = itag;
        cdb_active = ca; cdb_tag = ctag; cdb_val = cval; cdb_rd_idx = crd;
        predict_fail = pf; rs1_idx = r1; rs2_idx = r2;
        push_expect();
        if (rdy) begin
            if (ca) begin
                if (crd != 0) begin
                    mval[crd] = cval;
                    if (mtag[crd] == ctag) mtag[crd] = 0;
                end
                mcnt = mcnt + 1;
            end
            if (pf) foreach (mtag[i]) mtag[i] = 0;
            else if (iv && ird != 0) mtag[ird] = itag;
        end
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 1);
    endtask

    task automatic reset_check(input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk_in); #1;
        rst_in = 0; rs1_idx = r1; rs2_idx = r2;
        foreach (mval[i]) begin
            mval[i] = 0;
            mtag[i] = 0;
        end
        mcnt = 0;
        push_expect();
    endtask

    task automatic random_steps(input int n);
        logic iv, ca, pf, rdy;
        logic [4:0] ird, crd, r1, r2;
        logic [TAG_W-1:0] itag, ctag;
        logic [XLEN-1:0] cval;
        for (int k = 0; k < n; k++) begin
            iv   = 1'($urandom_range(1));
            ird  = 5'($urandom_range(31));
            itag = TAG_W'($urandom_range(15, 1));
            ca   = 1'($urandom_range(1));
            crd  = 5'($urandom_range(31));
            ctag = (mtag[crd] != 0 && $urandom_range(3) != 0) ? mtag[crd] : TAG_W'($urandom_range(15, 1));
            cval = $urandom;
            pf   = $urandom_range(15) == 0;
            rdy  = $urandom_range(7) != 0;
            r1   = $urandom_range(2) == 0 ? crd : 5'($urandom_range(31));
            r2   = $urandom_range(2) == 0 ? ird : 5'($urandom_range(31));
            step(iv, ird, itag, ca, ctag, cval, crd, pf, r1, r2, rdy);
        end
    endtask

    always @(negedge clk_in) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            vecs++;
            if (rs1_val !== me.v1 || rs1_tag !== me.t1) begin
                errs++;
                $display("FAIL rs1 vec %0d idx %0d: got val=%h tag=%0d, expected val=%h tag=%0d", vecs, rs1_idx, rs1_val, rs1_tag, me.v1, me.t1);
            end
            if (rs2_val !== me.v2 || rs2_tag !== me.t2) begin
                errs++;
                $display("FAIL rs2 vec %0d idx %0d: got val=%h tag=%0d, expected val=%h tag=%0d", vecs, rs2_idx, rs2_val, rs2_tag, me.v2, me.t2);
            end
            if (commit_cnt !== me.cnt) begin
                errs++;
                $display("FAIL commit_cnt vec %0d: got %0d, expected %0d", vecs, commit_cnt, me.cnt);
            end
        end
    end

    initial begin
        foreach (mval[i]) begin
            mval[i] = 0;
            mtag[i] = 0;
        end
        reset_check(5, 7);
        step(1, 5, 3, 0, 0, 0, 0, 0, 5, 0, 1);
        idle(5, 0);
        step(0, 0, 0, 1, 3, 32'hDEADBEEF, 5, 0, 5, 5, 1);
        idle(5, 0);
        step(1, 7, 2, 0, 0, 0, 0, 0, 7, 0, 1);
        step(1, 7, 4, 0, 0, 0, 0, 0, 7, 0, 1);
        step(0, 0, 0, 1, 2, 32'h11, 7, 0, 7, 0, 1);
        idle(7, 0);
        step(0, 0, 0, 1, 4, 32'h22, 7, 0, 7, 0, 1);
        idle(7, 0);
        step(1, 9, 1, 0, 0, 0, 0, 0, 9, 0, 1);
        step(1, 9, 6, 1, 1, 32'h55, 9, 0, 9, 9, 1);
        idle(9, 0);
        step(1, 3, 2, 0, 0, 0, 0, 0, 3, 4, 1);
        step(1, 4, 5, 0, 0, 0, 0, 0, 3, 4, 1);
        step(1, 8, 6, 1, 2, 32'h7, 3, 1, 3, 4, 1);
        idle(3, 4);
        idle(8, 0);
        step(1, 0, 3, 1, 3, 32'hFF, 0, 0, 0, 0, 1);
        idle(0, 0);
        step(1, 10, 5, 1, 0, 32'h99, 10, 0, 10, 10, 0);
        step(1, 11, 5, 1, 0, 32'h98, 5, 0, 11, 5, 0);
        idle(10, 11);
        idle(5, 0);
        random_steps(300);
        reset_check(5, 9);
        idle(5, 9);
        random_steps(200);
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk_in);
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d expected responses never checked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
